// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage sequencer for a variable-latency imem; FETCH_CTRL_PERF_EN adds perf counters
module fetch_controller #(
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] PCF,
    input  logic         PCSrcW,
    input  logic         BranchTakenE,
    input  logic         HazStallF,
    input  logic         HazStallD,
    input  logic         HazFlushD,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    output logic [N-1:0] InstrF,
    output logic         StallF,
    output logic         StallD,
    output logic         FlushD,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]  perf_stall_cnt,
    output logic [15:0]  perf_squash_cnt,
`endif
    output logic         fetch_err
);

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t       state_q, state_d;
    logic         squash_q, squash_d;
    logic [N-1:0] buf_q, addr_q;
    logic [7:0]   wait_cnt;
    logic         buf_load, bubble, redirect;

    assign redirect = PCSrcW | BranchTakenE;

    always_comb begin
        state_d   = state_q;
        squash_d  = squash_q;
        buf_load  = 1'b0;
        bubble    = 1'b0;
        imem_req  = 1'b0;
        imem_addr = addr_q;
        InstrF    = '0;
        StallF    = 1'b1;
        StallD    = HazStallD;
        case (state_q)
            S_ISSUE: begin
                imem_req  = 1'b1;
                imem_addr = PCF;
                bubble    = !HazStallD;
                state_d   = S_WAIT;
                if (redirect) begin
                    StallF   = 1'b0;
                    squash_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (!imem_ack) begin
                    StallF = !redirect;
                    bubble = !HazStallD;
                    if (redirect) squash_d = 1'b1;
                end else if (squash_q || redirect) begin
                    // response belongs to the wrong path: drop it and refetch
                    squash_d = 1'b0;
                    StallF   = !redirect;
                    bubble   = 1'b1;
                    state_d  = S_ISSUE;
                end else if (!HazStallD) begin
                    InstrF  = imem_rdata;
                    StallF  = HazStallF;
                    StallD  = 1'b0;
                    state_d = S_ISSUE;
                end else begin
                    buf_load = 1'b1;
                    StallD   = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                InstrF = buf_q;
                if (redirect) begin
                    StallF  = 1'b0;
                    state_d = S_ISSUE;
                end else if (!HazStallD) begin
                    StallF  = 1'b0;
                    StallD  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            StallF   = 1'b1;
            StallD   = 1'b0;
            bubble   = 1'b1;
            InstrF   = '0;
        end
        FlushD = redirect | HazFlushD | bubble;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_ISSUE;
            squash_q  <= 1'b0;
            buf_q     <= '0;
            addr_q    <= '0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            if (state_q == S_ISSUE) addr_q <= PCF;
            if (buf_load) buf_q <= imem_rdata;
            // flag rises once the TIMEOUT-th ack-less wait cycle completes
            if (state_q == S_WAIT && !imem_ack) begin
                if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                if (wait_cnt >= 8'(TIMEOUT - 1)) fetch_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (state_q == S_WAIT || state_q == S_HOLD)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (state_q == S_WAIT && imem_ack && (squash_q || redirect))
                perf_squash_cnt <= perf_squash_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed vector bench for fetch_controller
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] PCF = '0;
    logic        PCSrcW = 1'b0, BranchTakenE = 1'b0;
    logic        HazStallF = 1'b0, HazStallD = 1'b0, HazFlushD = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, StallF, StallD, FlushD, fetch_err;
    logic [31:0] imem_addr, InstrF;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_squash_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_controller #(.N(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .HazStallF(HazStallF), .HazStallD(HazStallD), .HazFlushD(HazFlushD),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .InstrF(InstrF),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
`ifdef FETCH_CTRL_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_squash_cnt(perf_squash_cnt),
`endif
        .fetch_err(fetch_err)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pcf;
        logic        psw, bte, hsf, hsd, hfd, ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        ci;
        logic [31:0] instr;
        logic        sf, sd, fd, err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [31:0] pc,
                                input logic psw, bte, hsf, hsd, hfd, ack,
                                input logic [31:0] rd, input logic q, input logic [31:0] a,
                                input logic ci, input logic [31:0] ins,
                                input logic sf, sd, fd, er);
        vec_t v;
        v.rst = r; v.pcf = pc; v.psw = psw; v.bte = bte; v.hsf = hsf; v.hsd = hsd;
        v.hfd = hfd; v.ack = ack; v.rdata = rd; v.req = q; v.addr = a; v.ci = ci;
        v.instr = ins; v.sf = sf; v.sd = sd; v.fd = fd; v.err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h expected %h", nm, row, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        @(negedge clk);
        rst = v.rst; PCF = v.pcf; PCSrcW = v.psw; BranchTakenE = v.bte;
        HazStallF = v.hsf; HazStallD = v.hsd; HazFlushD = v.hfd;
        imem_ack = v.ack; imem_rdata = v.rdata;
        #2;
        chk("imem_req", row, {31'd0, imem_req}, {31'd0, v.req});
        if (v.req) chk("imem_addr", row, imem_addr, v.addr);
        if (v.ci) chk("InstrF", row, InstrF, v.instr);
        chk("StallF", row, {31'd0, StallF}, {31'd0, v.sf});
        chk("StallD", row, {31'd0, StallD}, {31'd0, v.sd});
        chk("FlushD", row, {31'd0, FlushD}, {31'd0, v.fd});
        chk("fetch_err", row, {31'd0, fetch_err}, {31'd0, v.err});
    endtask

    vec_t rst_row;

    initial begin
        rst_row = mk(1, 0, 0,0,0,0,0,0, 0, 0,0, 1,0, 1,0,1,0);

        // reset, then one fetch acked three cycles after the request
        tbl.push_back(rst_row);
        tbl.push_back(rst_row);
        tbl.push_back(mk(0, 0, 0,0,0,0,0,0, 0,          1,0, 0,0,          1,0,1,0));
        tbl.push_back(mk(0, 0, 0,0,0,0,0,0, 0,          0,0, 0,0,          1,0,1,0));
        tbl.push_back(mk(0, 0, 0,0,0,0,0,0, 0,          0,0, 0,0,          1,0,1,0));
        tbl.push_back(mk(0, 0, 0,0,0,0,0,1, 32'hE3A01005, 0,0, 1,32'hE3A01005, 0,0,0,0));
        // zero-wait memory: four instructions in eight cycles
        tbl.push_back(rst_row);
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(0, 32'(4*i), 0,0,0,0,0,0, 0,           1,32'(4*i), 0,0,            1,0,1,0));
            tbl.push_back(mk(0, 32'(4*i), 0,0,0,0,0,1, 32'hA0 + 32'(i), 0,0, 1,32'hA0 + 32'(i), 0,0,0,0));
        end
        // decode stall across the ack, held, then released
        tbl.push_back(mk(0, 32'h44, 0,0,0,0,0,0, 0,            1,32'h44, 0,0,            1,0,1,0));
        tbl.push_back(mk(0, 32'h44, 0,0,0,1,0,1, 32'h12345678, 0,0,      0,0,            1,1,0,0));
        tbl.push_back(mk(0, 32'h44, 0,0,0,1,0,0, 0,            0,0,      1,32'h12345678, 1,1,0,0));
        tbl.push_back(mk(0, 32'h44, 0,0,0,1,0,0, 0,            0,0,      1,32'h12345678, 1,1,0,0));
        tbl.push_back(mk(0, 32'h44, 0,0,0,0,0,0, 0,            0,0,      1,32'h12345678, 0,0,0,0));
        // redirect while holding wins over the buffered instruction
        tbl.push_back(mk(0, 32'h48, 0,0,0,0,0,0, 0,     1,32'h48, 0,0,     1,0,1,0));
        tbl.push_back(mk(0, 32'h48, 0,0,0,1,0,1, 32'h9, 0,0,      0,0,     1,1,0,0));
        tbl.push_back(mk(0, 32'h48, 1,0,0,1,0,0, 0,     0,0,      0,0,     0,1,1,0));
        tbl.push_back(mk(0, 32'h80, 0,0,0,0,0,0, 0,     1,32'h80, 0,0,     1,0,1,0));
        // hazard fetch stall and hazard flush on clean acks
        tbl.push_back(mk(0, 32'h80, 0,0,1,0,0,1, 32'h55, 0,0,     1,32'h55, 1,0,0,0));
        tbl.push_back(mk(0, 32'h80, 0,0,0,0,1,0, 0,      1,32'h80, 0,0,       1,0,1,0));
        tbl.push_back(mk(0, 32'h80, 0,0,0,0,1,1, 32'h66, 0,0,     1,32'h66, 0,0,1,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // branch in the first wait cycle squashes the pending response
        apply(rst_row, 100);
        apply(mk(0, 32'h10, 0,0,0,0,0,0, 0,            1,32'h10, 0,0,     1,0,1,0), 101);
        apply(mk(0, 32'h10, 0,1,0,0,0,0, 0,            0,0,      0,0,     0,0,1,0), 102);
        apply(mk(0, 32'h40, 0,0,0,0,0,0, 0,            0,0,      0,0,     1,0,1,0), 103);
        apply(mk(0, 32'h40, 0,0,0,0,0,1, 32'hDEADBEEF, 0,0,      0,0,     1,0,1,0), 104);
        apply(mk(0, 32'h40, 0,0,0,0,0,0, 0,            1,32'h40, 0,0,     1,0,1,0), 105);
        apply(mk(0, 32'h40, 0,0,0,0,0,1, 32'hE1,       0,0,      1,32'hE1, 0,0,0,0), 106);
`ifdef FETCH_CTRL_PERF_EN
        @(negedge clk);
        #2;
        chk("perf_squash_cnt", 107, {16'd0, perf_squash_cnt}, 32'd1);
        chk("perf_stall_cnt", 107, perf_stall_cnt, 32'd4);
`endif

        // timeout: flag rises after the 64th ack-less wait cycle and is sticky
        apply(rst_row, 200);
        apply(mk(0, 0, 0,0,0,0,0,0, 0, 1,0, 0,0, 1,0,1,0), 201);
        for (int k = 1; k <= 64; k++)
            apply(mk(0, 0, 0,0,0,0,0,0, 0, 0,0, 0,0, 1,0,1,0), 201 + k);
        apply(mk(0, 0, 0,0,0,0,0,0, 0,      0,0, 0,0,      1,0,1,1), 266);
        apply(mk(0, 0, 0,0,0,0,0,1, 32'h33, 0,0, 1,32'h33, 0,0,0,1), 267);
        apply(mk(0, 4, 0,0,0,0,0,0, 0,      1,4, 0,0,      1,0,1,1), 268);
        apply(mk(1, 0, 0,0,0,0,0,0, 0,      0,0, 1,0,      1,0,1,1), 269);
        apply(rst_row, 270);

        // reset during wait; stale ack after reset is ignored
        apply(mk(0, 32'h20, 0,0,0,0,0,0, 0,      1,32'h20, 0,0,      1,0,1,0), 300);
        apply(mk(0, 32'h20, 0,0,0,0,0,0, 0,      0,0,      0,0,      1,0,1,0), 301);
        apply(rst_row, 302);
        apply(mk(0, 0,      0,0,0,0,0,1, 32'hBAD, 1,0,     0,0,      1,0,1,0), 303);
        apply(mk(0, 0,      0,0,0,0,0,0, 0,      0,0,      0,0,      1,0,1,0), 304);
        apply(mk(0, 0,      0,0,0,0,0,1, 32'h77, 0,0,      1,32'h77, 0,0,0,0), 305);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
